// File: rtl/alu_rs_pkg.sv
// Shared sizes, opcode constants and the reservation-station entry layout
// used by the ALU reservation station and its helpers.
package alu_rs_pkg;

  localparam int RS_SIZE = 8;
  localparam int RS_BIT  = 3;
  localparam int ROB_BIT = 4;

  localparam logic [6:0] B_TYPE  = 7'b1100011;
  localparam logic [6:0] I_ARITH = 7'b0010011;
  localparam logic [6:0] R_ARITH = 7'b0110011;

  typedef struct packed {
    logic               busy;
    logic [2:0]         op;
    logic [6:0]         op_type;
    logic               op_addition;
    logic [31:0]        vi;
    logic [31:0]        vj;
    logic               qi_valid;
    logic               qj_valid;
    logic [ROB_BIT-1:0] qi;
    logic [ROB_BIT-1:0] qj;
    logic [ROB_BIT-1:0] rob_entry;
  } rs_entry_t;

  // True when a broadcast port is active and carries the awaited tag.
  function automatic logic cdb_hit(input logic port_valid,
                                   input logic [ROB_BIT-1:0] port_tag,
                                   input logic [ROB_BIT-1:0] want_tag);
    return port_valid && (port_tag == want_tag);
  endfunction

endpackage

// File: rtl/rs_pick.sv
// Lowest-index priority encoder: reports whether any request bit is set
// and the index of the lowest one.
module rs_pick #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] req,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers issued ops until both operands are known,
// snoops both CDB ports, and dispatches the lowest ready entry each cycle.
module alu_rs
  import alu_rs_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               rob_clear_up,
  input  logic               inst_valid,
  input  logic [2:0]         inst_op,
  input  logic [6:0]         inst_op_type,
  input  logic               inst_op_addition,
  input  logic [31:0]        inst_vi,
  input  logic [31:0]        inst_vj,
  input  logic               inst_qi_valid,
  input  logic               inst_qj_valid,
  input  logic [ROB_BIT-1:0] inst_qi,
  input  logic [ROB_BIT-1:0] inst_qj,
  input  logic [ROB_BIT-1:0] inst_rob_entry,
  output logic               full,
  input  logic               cdb_alu_ready,
  input  logic [31:0]        cdb_alu_res,
  input  logic [ROB_BIT-1:0] cdb_alu_entry,
  input  logic               cdb_lsb_ready,
  input  logic [31:0]        cdb_lsb_res,
  input  logic [ROB_BIT-1:0] cdb_lsb_entry,
  output logic               valid,
  output logic [31:0]        vi,
  output logic [31:0]        vj,
  output logic [2:0]         op,
  output logic [6:0]         op_type,
  output logic               op_addition,
  output logic [ROB_BIT-1:0] rob_entry
);

  rs_entry_t ent_q [RS_SIZE];
  rs_entry_t ent_d [RS_SIZE];

  logic [RS_SIZE-1:0] free_req;
  logic [RS_SIZE-1:0] ready_req;
  logic               free_found;
  logic               ready_found;
  logic [RS_BIT-1:0]  free_idx;
  logic [RS_BIT-1:0]  ready_idx;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      free_req[i]  = !ent_q[i].busy;
      ready_req[i] = ent_q[i].busy && !ent_q[i].qi_valid && !ent_q[i].qj_valid;
    end
  end

  rs_pick #(.WIDTH(RS_SIZE), .IDX_W(RS_BIT)) u_free_pick (
    .req   (free_req),
    .found (free_found),
    .index (free_idx)
  );

  rs_pick #(.WIDTH(RS_SIZE), .IDX_W(RS_BIT)) u_ready_pick (
    .req   (ready_req),
    .found (ready_found),
    .index (ready_idx)
  );

  assign full = !free_found;

  // Wakeup, dispatch-free and issue never collide: dispatch only takes entries
  // with no pending tag, and issue only takes entries that are not busy.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].busy && ent_q[i].qi_valid) begin
        if (cdb_hit(cdb_alu_ready, cdb_alu_entry, ent_q[i].qi)) begin
          ent_d[i].vi       = cdb_alu_res;
          ent_d[i].qi_valid = 1'b0;
        end else if (cdb_hit(cdb_lsb_ready, cdb_lsb_entry, ent_q[i].qi)) begin
          ent_d[i].vi       = cdb_lsb_res;
          ent_d[i].qi_valid = 1'b0;
        end
      end
      if (ent_q[i].busy && ent_q[i].qj_valid) begin
        if (cdb_hit(cdb_alu_ready, cdb_alu_entry, ent_q[i].qj)) begin
          ent_d[i].vj       = cdb_alu_res;
          ent_d[i].qj_valid = 1'b0;
        end else if (cdb_hit(cdb_lsb_ready, cdb_lsb_entry, ent_q[i].qj)) begin
          ent_d[i].vj       = cdb_lsb_res;
          ent_d[i].qj_valid = 1'b0;
        end
      end
    end

    if (ready_found) begin
      ent_d[ready_idx].busy = 1'b0;
    end

    if (inst_valid && free_found) begin
      ent_d[free_idx].busy        = 1'b1;
      ent_d[free_idx].op          = inst_op;
      ent_d[free_idx].op_type     = inst_op_type;
      ent_d[free_idx].op_addition = inst_op_addition;
      ent_d[free_idx].rob_entry   = inst_rob_entry;
      ent_d[free_idx].qi          = inst_qi;
      ent_d[free_idx].qj          = inst_qj;
      ent_d[free_idx].vi          = inst_vi;
      ent_d[free_idx].vj          = inst_vj;
      ent_d[free_idx].qi_valid    = inst_qi_valid;
      ent_d[free_idx].qj_valid    = inst_qj_valid;
      // A producer broadcasting in the issue cycle would otherwise be missed.
      if (inst_qi_valid) begin
        if (cdb_hit(cdb_alu_ready, cdb_alu_entry, inst_qi)) begin
          ent_d[free_idx].vi       = cdb_alu_res;
          ent_d[free_idx].qi_valid = 1'b0;
        end else if (cdb_hit(cdb_lsb_ready, cdb_lsb_entry, inst_qi)) begin
          ent_d[free_idx].vi       = cdb_lsb_res;
          ent_d[free_idx].qi_valid = 1'b0;
        end
      end
      if (inst_qj_valid) begin
        if (cdb_hit(cdb_alu_ready, cdb_alu_entry, inst_qj)) begin
          ent_d[free_idx].vj       = cdb_alu_res;
          ent_d[free_idx].qj_valid = 1'b0;
        end else if (cdb_hit(cdb_lsb_ready, cdb_lsb_entry, inst_qj)) begin
          ent_d[free_idx].vj       = cdb_lsb_res;
          ent_d[free_idx].qj_valid = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in || rob_clear_up) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= '0;
      end
      valid       <= 1'b0;
      vi          <= '0;
      vj          <= '0;
      op          <= '0;
      op_type     <= '0;
      op_addition <= 1'b0;
      rob_entry   <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= ent_d[i];
      end
      valid <= ready_found;
      if (ready_found) begin
        vi          <= ent_q[ready_idx].vi;
        vj          <= ent_q[ready_idx].vj;
        op          <= ent_q[ready_idx].op;
        op_type     <= ent_q[ready_idx].op_type;
        op_addition <= ent_q[ready_idx].op_addition;
        rob_entry   <= ent_q[ready_idx].rob_entry;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for the ALU reservation station: issue, bypass, wakeup,
// fill/drain ordering, flush and pause behaviour.
module tb_alu_rs;

  localparam int RB = 4;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          rob_clear_up;
  logic          inst_valid;
  logic [2:0]    inst_op;
  logic [6:0]    inst_op_type;
  logic          inst_op_addition;
  logic [31:0]   inst_vi;
  logic [31:0]   inst_vj;
  logic          inst_qi_valid;
  logic          inst_qj_valid;
  logic [RB-1:0] inst_qi;
  logic [RB-1:0] inst_qj;
  logic [RB-1:0] inst_rob_entry;
  logic          full;
  logic          cdb_alu_ready;
  logic [31:0]   cdb_alu_res;
  logic [RB-1:0] cdb_alu_entry;
  logic          cdb_lsb_ready;
  logic [31:0]   cdb_lsb_res;
  logic [RB-1:0] cdb_lsb_entry;
  logic          valid;
  logic [31:0]   vi;
  logic [31:0]   vj;
  logic [2:0]    op;
  logic [6:0]    op_type;
  logic          op_addition;
  logic [RB-1:0] rob_entry;

  int total = 0;
  int bad   = 0;
  logic [RB-1:0] exp_q[$];

  alu_rs dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear_up(rob_clear_up),
    .inst_valid(inst_valid), .inst_op(inst_op), .inst_op_type(inst_op_type),
    .inst_op_addition(inst_op_addition), .inst_vi(inst_vi), .inst_vj(inst_vj),
    .inst_qi_valid(inst_qi_valid), .inst_qj_valid(inst_qj_valid),
    .inst_qi(inst_qi), .inst_qj(inst_qj), .inst_rob_entry(inst_rob_entry),
    .full(full),
    .cdb_alu_ready(cdb_alu_ready), .cdb_alu_res(cdb_alu_res), .cdb_alu_entry(cdb_alu_entry),
    .cdb_lsb_ready(cdb_lsb_ready), .cdb_lsb_res(cdb_lsb_res), .cdb_lsb_entry(cdb_lsb_entry),
    .valid(valid), .vi(vi), .vj(vj), .op(op), .op_type(op_type),
    .op_addition(op_addition), .rob_entry(rob_entry)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    inst_valid = 1'b0; inst_op = 3'd0; inst_op_type = 7'd0; inst_op_addition = 1'b0;
    inst_vi = '0; inst_vj = '0; inst_qi_valid = 1'b0; inst_qj_valid = 1'b0;
    inst_qi = '0; inst_qj = '0; inst_rob_entry = '0;
    cdb_alu_ready = 1'b0; cdb_alu_res = '0; cdb_alu_entry = '0;
    cdb_lsb_ready = 1'b0; cdb_lsb_res = '0; cdb_lsb_entry = '0;
  endtask

  task automatic drive_inst(input logic [2:0] f3, input logic [6:0] opc, input logic add,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic qiv, input logic [RB-1:0] qi,
                            input logic qjv, input logic [RB-1:0] qj,
                            input logic [RB-1:0] rob);
    inst_valid = 1'b1; inst_op = f3; inst_op_type = opc; inst_op_addition = add;
    inst_vi = a; inst_vj = b; inst_qi_valid = qiv; inst_qi = qi;
    inst_qj_valid = qjv; inst_qj = qj; inst_rob_entry = rob;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; rob_clear_up = 1'b0;
    idle_inputs();

    // 1: reset
    step(); step();
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_vi", vi, 32'd0);
    check("rst_vj", vj, 32'd0);
    check("rst_rob", 32'(rob_entry), 32'd0);
    check("rst_optype", 32'(op_type), 32'd0);
    rst_in = 1'b1;
    step();
    check("post_rst_valid", 32'(valid), 32'd0);

    // 2: ready add, two-edge latency, one-cycle pulse
    drive_inst(3'b000, 7'b0110011, 1'b1, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    step();
    idle_inputs();
    check("t2_not_yet", 32'(valid), 32'd0);
    step();
    check("t2_valid", 32'(valid), 32'd1);
    check("t2_vi", vi, 32'd5);
    check("t2_vj", vj, 32'd7);
    check("t2_rob", 32'(rob_entry), 32'd3);
    check("t2_optype", 32'(op_type), 32'h33);
    check("t2_add", 32'(op_addition), 32'd1);
    step();
    check("t2_pulse_end", 32'(valid), 32'd0);

    // 3: qi pending, woken by the LSB port
    drive_inst(3'b100, 7'b0010011, 1'b0, 32'd0, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd5);
    step();
    idle_inputs();
    step();
    check("t3_waiting", 32'(valid), 32'd0);
    cdb_lsb_ready = 1'b1; cdb_lsb_entry = 4'd2; cdb_lsb_res = 32'h10;
    step();
    idle_inputs();
    check("t3_wake_edge", 32'(valid), 32'd0);
    step();
    check("t3_valid", 32'(valid), 32'd1);
    check("t3_vi", vi, 32'h10);
    check("t3_vj", vj, 32'd1);
    check("t3_rob", 32'(rob_entry), 32'd5);
    check("t3_op", 32'(op), 32'd4);
    step();

    // 4: same-cycle bypass from the ALU port
    drive_inst(3'b001, 7'b1100011, 1'b0, 32'd3, 32'd0, 1'b0, 4'd0, 1'b1, 4'd4, 4'd6);
    cdb_alu_ready = 1'b1; cdb_alu_entry = 4'd4; cdb_alu_res = 32'd9;
    step();
    idle_inputs();
    step();
    check("t4_valid", 32'(valid), 32'd1);
    check("t4_vj", vj, 32'd9);
    check("t4_vi", vi, 32'd3);
    check("t4_rob", 32'(rob_entry), 32'd6);
    step();

    // 5: fill all entries on tag 7, ignored 9th, drain in entry order
    for (int i = 0; i < 8; i++) begin
      drive_inst(3'b000, 7'b0110011, 1'b0, 32'd0, 32'(i), 1'b1, 4'd7, 1'b0, 4'd0, RB'(i));
      exp_q.push_back(RB'(i));
      step();
    end
    check("t5_full", 32'(full), 32'd1);
    drive_inst(3'b000, 7'b0110011, 1'b0, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
    step();
    idle_inputs();
    check("t5_full_9th", 32'(full), 32'd1);
    check("t5_no_disp", 32'(valid), 32'd0);
    cdb_alu_ready = 1'b1; cdb_alu_entry = 4'd7; cdb_alu_res = 32'hAA;
    step();
    idle_inputs();
    check("t5_wake_full", 32'(full), 32'd1);
    for (int i = 0; i < 8; i++) begin
      logic [RB-1:0] exp_rob;
      step();
      exp_rob = (exp_q.size() != 0) ? exp_q.pop_front() : 4'd0;
      check("t5_valid", 32'(valid), 32'd1);
      check("t5_rob", 32'(rob_entry), 32'(exp_rob));
      check("t5_vi", vi, 32'hAA);
      check("t5_vj", vj, 32'(exp_rob));
      if (i == 0) check("t5_full_drop", 32'(full), 32'd0);
    end
    step();
    check("t5_drained", 32'(valid), 32'd0);

    // 6: flush with pending entries and a dispatch in flight
    for (int i = 0; i < 3; i++) begin
      drive_inst(3'b000, 7'b0110011, 1'b0, 32'd0, 32'd0, 1'b1, 4'd6, 1'b0, 4'd0, RB'(i + 1));
      step();
    end
    drive_inst(3'b000, 7'b0110011, 1'b0, 32'd2, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
    step();
    idle_inputs();
    step();
    check("t6_pre_valid", 32'(valid), 32'd1);
    check("t6_pre_rob", 32'(rob_entry), 32'd9);
    rob_clear_up = 1'b1;
    step();
    rob_clear_up = 1'b0;
    check("t6_flush_valid", 32'(valid), 32'd0);
    check("t6_flush_full", 32'(full), 32'd0);
    check("t6_flush_rob", 32'(rob_entry), 32'd0);
    cdb_alu_ready = 1'b1; cdb_alu_entry = 4'd6; cdb_alu_res = 32'h55;
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_no_disp", 32'(valid), 32'd0);
    end

    // 7: pause freezes outputs and keeps dispatch order
    drive_inst(3'b010, 7'b0110011, 1'b0, 32'd8, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd8);
    step();
    drive_inst(3'b011, 7'b0110011, 1'b0, 32'd9, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
    step();
    check("t7_first", 32'(rob_entry), 32'd8);
    drive_inst(3'b101, 7'b0010011, 1'b0, 32'd10, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd10);
    step();
    check("t7_second", 32'(rob_entry), 32'd9);
    drive_inst(3'b110, 7'b0110011, 1'b0, 32'd12, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd12);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t7_hold_valid", 32'(valid), 32'd1);
      check("t7_hold_rob", 32'(rob_entry), 32'd9);
      check("t7_hold_vi", vi, 32'd9);
    end
    idle_inputs();
    rdy_in = 1'b1;
    step();
    check("t7_resume_valid", 32'(valid), 32'd1);
    check("t7_resume_rob", 32'(rob_entry), 32'd10);
    check("t7_resume_vi", vi, 32'd10);
    step();
    check("t7_no_stall_issue", 32'(valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
